mon_exp_ctrl: RTL
=================

// Module: mon_exp_ctrl
// PURPOSE
//  Sequencer for right-to-left... no: left-to-right binary modular exponentiation, R = X^E mod M.
//  Sits directly upstream of mon_prod: issues every Montgomery product (A,B,M,num_words,start),
//  consumes P on stop. Handles domain entry (via R2 = 2^(2*bitLen) mod M) and exit (MonPro(.,1)).
// PARAMETERS
//  bitLen      64  operand width (X, M, R2, result, mon_prod A/B/M/P)
//  countWidth  5   width of num_words, passed through to mon_prod unchanged
//  expLen      64  exponent width; bits processed MSB first
// PORTS
//  clk           in   1           single clock, all logic on posedge
//  reset         in   1           synchronous, active-high
//  start         in   1           begin exponentiation; sampled in IDLE only
//  X             in   bitLen      base, X < M
//  E             in   expLen      exponent
//  M             in   bitLen      odd modulus, M > 1
//  R2            in   bitLen      2^(2*bitLen) mod M, precomputed by caller
//  num_words     in   countWidth  forwarded to mon_prod
//  busy          out  1           high from accepted start until done
//  done          out  1           one-cycle pulse, result valid
//  result        out  bitLen      X^E mod M, held until next accepted start
//  mp_start      out  1           mon_prod start
//  mp_A, mp_B    out  bitLen      mon_prod operands
//  mp_M          out  bitLen      latched M
//  mp_num_words  out  countWidth  latched num_words
//  mp_stop       in   1           mon_prod completion
//  mp_P          in   bitLen      mon_prod product, valid while mp_stop high
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, mp_start=0, mp_A=mp_B=mp_M=0, mp_num_words=0.
//  start in IDLE: latch X,E,M,R2,num_words; busy=1 next cycle. start while busy ignored.
//  Registers: Xb (X in Montgomery domain), Acc, bit index i (expLen-1 down to 0).
//  States / operation issued:
//   IDLE   -> TO_X    on start
//   TO_X   Xb  = MonPro(X, R2)              -> TO_ONE
//   TO_ONE Acc = MonPro(R2, 1) (= R mod M)  -> SQR, i = expLen-1
//   SQR    Acc = MonPro(Acc, Acc)           -> MUL if E[i] else (i==0 ? FROM : SQR, i--)
//   MUL    Acc = MonPro(Acc, Xb)            -> i==0 ? FROM : SQR, i--
//   FROM   result = MonPro(Acc, 1)          -> DONE
//   DONE   done=1 for one cycle, busy=0     -> IDLE
//  Per-op handshake (inside each op state, three sub-phases):
//   ISSUE: wait mp_stop==0; drive mp_A/mp_B; assert mp_start.
//   WAIT : hold mp_start=1 and mp_A/mp_B stable until mp_stop==1.
//   CAPT : on first cycle mp_stop==1, register mp_P into the target, drop mp_start,
//          advance state. mp_start is low for at least 1 cycle between ops.
//  All leading zero bits of E processed (no skip): op count = 3 + expLen + popcount(E),
//   independent of mon_prod latency; total latency = sum of op latencies + fixed overhead.
//  E == 0: no MUL; result = 1. E == 1: result = X. X == 0 with E > 0: result = 0.
//  mp_M / mp_num_words constant for the whole run (latched copies).
//  mp_stop high while in ISSUE (stale from previous op): no issue until it falls.
//  Reset mid-operation: IDLE next cycle, mp_start=0, done not pulsed, result=0.
//  done and a new start in the same cycle: start ignored (controller not yet IDLE).
// TESTING
//  Bench uses behavioural mon_prod model (P = A*B*R^-1 mod M, programmable latency 1..20),
//  R = 2^bitLen, R2 computed by bench from M; all defaults.
//  1. X=2, E=10, M=311 -> result=91; exactly 69 mp_start rising edges; one done pulse.
//  2. X=216, E=2, M=311 -> 6; X=216, E=1 -> 216; X=216, E=0 -> 1; X=0, E=5 -> 0.
//  3. X=310, E=3, M=311 (X=-1) -> 310; repeat with model latency 1 and 20 -> same result.
//  4. start pulsed again during run of case 1 -> ignored, result still 91, op count 69.
//  5. reset asserted in SQR of case 1 -> next cycle busy=0, mp_start=0, no done;
//     fresh start afterwards -> result 91.
//  6. model holds mp_stop high 3 extra cycles after capture -> no new mp_start until low;
//     mp_A/mp_B never change while mp_start high (assertion).

Source files
------------

// File: rtl/mon_exp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mon_exp_ctrl                                               |
// | Description : Left-to-right binary modular exponentiation sequencer,     |
// |               R = X^E mod M, driving an external Montgomery multiplier   |
// |               (mon_prod). Enters the Montgomery domain through R2 and    |
// |               leaves it through MonPro(Acc, 1).                          |
// | Ports       : clk, reset            clock / sync active-high reset       |
// |               start, X, E, M, R2,   job request and operands, sampled    |
// |               num_words             only while idle                      |
// |               busy, done, result    job status and X^E mod M             |
// |               mp_start, mp_A, mp_B, multiplier request side              |
// |               mp_M, mp_num_words                                         |
// |               mp_stop, mp_P         multiplier completion and product    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mon_exp_ctrl #(
   parameter int BIT_LEN     = 64,
   parameter int COUNT_WIDTH = 5,
   parameter int EXP_LEN     = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [BIT_LEN-1:0]     X,
   input  logic [EXP_LEN-1:0]     E,
   input  logic [BIT_LEN-1:0]     M,
   input  logic [BIT_LEN-1:0]     R2,
   input  logic [COUNT_WIDTH-1:0] num_words,
   output logic                   busy,
   output logic                   done,
   output logic [BIT_LEN-1:0]     result,
   output logic                   mp_start,
   output logic [BIT_LEN-1:0]     mp_A,
   output logic [BIT_LEN-1:0]     mp_B,
   output logic [BIT_LEN-1:0]     mp_M,
   output logic [COUNT_WIDTH-1:0] mp_num_words,
   input  logic                   mp_stop,
   input  logic [BIT_LEN-1:0]     mp_P
);

   localparam int                 c_idx_w   = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
   localparam logic [BIT_LEN-1:0] c_one     = BIT_LEN'(1);
   localparam logic [c_idx_w-1:0] c_idx_top = c_idx_w'(EXP_LEN - 1);
   localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TO_X   = 3'd1,
      S_TO_ONE = 3'd2,
      S_SQR    = 3'd3,
      S_MUL    = 3'd4,
      S_FROM   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t               r_state;
   logic                 r_wait;    // 0: issue phase, 1: waiting for mp_stop
   logic [BIT_LEN-1:0]   r_x;
   logic [EXP_LEN-1:0]   r_e;
   logic [BIT_LEN-1:0]   r_r2;
   logic [BIT_LEN-1:0]   r_xb;      // base in Montgomery domain
   logic [BIT_LEN-1:0]   r_acc;     // running accumulator, Montgomery domain
   logic [c_idx_w-1:0]   r_idx;     // exponent bit being processed

   logic [BIT_LEN-1:0]   w_op_a;
   logic [BIT_LEN-1:0]   w_op_b;
   logic                 w_last;
   logic                 w_ebit;

   // Operand pair for the product the current state issues.
   always_comb begin
      w_op_a = r_acc;
      w_op_b = r_acc;
      case (r_state)
         S_TO_X: begin
            w_op_a = r_x;
            w_op_b = r_r2;
         end
         S_TO_ONE: begin
            w_op_a = r_r2;
            w_op_b = c_one;
         end
         S_MUL:   w_op_b = r_xb;
         S_FROM:  w_op_b = c_one;
         default: ;
      endcase
   end

   assign w_last = (r_idx == '0);
   assign w_ebit = r_e[r_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait       <= 1'b0;
         r_x          <= '0;
         r_e          <= '0;
         r_r2         <= '0;
         r_xb         <= '0;
         r_acc        <= '0;
         r_idx        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         mp_start     <= 1'b0;
         mp_A         <= '0;
         mp_B         <= '0;
         mp_M         <= '0;
         mp_num_words <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x          <= X;
                  r_e          <= E;
                  r_r2         <= R2;
                  mp_M         <= M;
                  mp_num_words <= num_words;
                  busy         <= 1'b1;
                  r_wait       <= 1'b0;
                  r_state      <= S_TO_X;
               end
            end

            S_TO_X, S_TO_ONE, S_SQR, S_MUL, S_FROM: begin
               if (!r_wait) begin
                  // A stop still high from the previous product blocks the issue.
                  if (!mp_stop) begin
                     mp_A     <= w_op_a;
                     mp_B     <= w_op_b;
                     mp_start <= 1'b1;
                     r_wait   <= 1'b1;
                  end
               end else if (mp_stop) begin
                  mp_start <= 1'b0;
                  r_wait   <= 1'b0;
                  case (r_state)
                     S_TO_X: begin
                        r_xb    <= mp_P;
                        r_state <= S_TO_ONE;
                     end
                     S_TO_ONE: begin
                        r_acc   <= mp_P;
                        r_idx   <= c_idx_top;
                        r_state <= S_SQR;
                     end
                     S_SQR: begin
                        r_acc <= mp_P;
                        if (w_ebit) begin
                           r_state <= S_MUL;
                        end else if (w_last) begin
                           r_state <= S_FROM;
                        end else begin
                           r_idx   <= r_idx - c_idx_one;
                           r_state <= S_SQR;
                        end
                     end
                     S_MUL: begin
                        r_acc <= mp_P;
                        if (w_last) begin
                           r_state <= S_FROM;
                        end else begin
                           r_idx   <= r_idx - c_idx_one;
                           r_state <= S_SQR;
                        end
                     end
                     S_FROM: begin
                        result  <= mp_P;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end

            // One cycle of settling so a start coincident with done is not taken.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
